// File: rtl/ec_cu_pkg.sv
// Shared state codes, opcode constants and accumulator-select encodings
// for the EC accumulator processor control unit.
package ec_cu_pkg;

    typedef enum logic [3:0] {
        ST_START  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD   = 4'd8,
        ST_STORE  = 4'd9,
        ST_ADD    = 4'd10,
        ST_SUB    = 4'd11,
        ST_INPUT  = 4'd12,
        ST_JZ     = 4'd13,
        ST_JPOS   = 4'd14,
        ST_HALT   = 4'd15
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_INPUT = 3'd4;
    localparam logic [2:0] OP_JZ    = 3'd5;
    localparam logic [2:0] OP_JPOS  = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_MEM = 2'b10;

    // Execute state entered from DECODE for a legal opcode.
    function automatic state_t op_to_state(input logic [2:0] op);
        state_t st;
        case (op)
            OP_LOAD:  st = ST_LOAD;
            OP_STORE: st = ST_STORE;
            OP_ADD:   st = ST_ADD;
            OP_SUB:   st = ST_SUB;
            OP_INPUT: st = ST_INPUT;
            OP_JZ:    st = ST_JZ;
            OP_JPOS:  st = ST_JPOS;
            OP_HALT:  st = ST_HALT;
            default:  st = ST_HALT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/ec_tick_gen.sv
// Clock-enable prescaler: counts 0..DIV-1 and raises tick for the single
// cycle in which the count sits at DIV-1.
module ec_tick_gen #(
    parameter int DIV   = 25_000_000,
    parameter int DIV_W = 25
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] count_r;

    // Free-running modulo-DIV counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {DIV_W{1'b0}};
        end else if (count_r == LAST) begin
            count_r <= {DIV_W{1'b0}};
        end else begin
            count_r <= count_r + DIV_W'(1);
        end
    end

    assign tick = (count_r == LAST);

endmodule

// File: rtl/ec_cu_stepped.sv
// EC control unit FSM on CLOCK_50 with prescaled free-run, single-step mode,
// edge-detected Enter/Step buttons and an illegal-opcode trap into HALT.
module ec_cu_stepped
    import ec_cu_pkg::*;
#(
    parameter int IR_W  = 3,
    parameter int DIV   = 25_000_000,
    parameter int DIV_W = 25
) (
    input  logic            CLOCK_50,
    input  logic            Reset,
    input  logic [IR_W-1:0] IR,
    input  logic            Aeq0,
    input  logic            Apos,
    input  logic            Enter,
    input  logic            Run,
    input  logic            Step,
    output logic            IRload,
    output logic            PCload,
    output logic            Aload,
    output logic            MemWr,
    output logic            JMPmux,
    output logic            Sub,
    output logic            Meminst,
    output logic [1:0]      Asel,
    output logic            Halt,
    output logic            Illegal,
    output logic [3:0]      state,
    output logic [3:0]      nstate
);

    state_t     state_r;
    state_t     state_nxt_s;
    logic       tick_s;
    logic       adv_s;
    logic [1:0] enter_sync_r;
    logic [1:0] step_sync_r;
    logic       enter_prev_r;
    logic       step_prev_r;
    logic       enter_edge_s;
    logic       step_edge_s;
    logic       enter_pend_r;
    logic       enter_clr_s;
    logic       illegal_r;
    logic       illegal_op_s;
    logic [2:0] op_s;

    ec_tick_gen #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_tick (
        .clk   (CLOCK_50),
        .reset (Reset),
        .tick  (tick_s)
    );

    assign op_s = IR[2:0];

    // Any set bit above the 3-bit opcode field is an undefined instruction.
    generate
        if (IR_W > 3) begin : g_wide_ir
            assign illegal_op_s = |IR[IR_W-1:3];
        end else begin : g_narrow_ir
            assign illegal_op_s = 1'b0;
        end
    endgenerate

    // Two-flop synchronisers plus previous-value flops for edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            enter_sync_r <= 2'b00;
            step_sync_r  <= 2'b00;
            enter_prev_r <= 1'b0;
            step_prev_r  <= 1'b0;
        end else begin
            enter_sync_r <= {enter_sync_r[0], Enter};
            step_sync_r  <= {step_sync_r[0], Step};
            enter_prev_r <= enter_sync_r[1];
            step_prev_r  <= step_sync_r[1];
        end
    end

    assign enter_edge_s = enter_sync_r[1] & ~enter_prev_r;
    assign step_edge_s  = step_sync_r[1] & ~step_prev_r;
    assign adv_s        = Run ? tick_s : step_edge_s;
    assign enter_clr_s  = (state_r == ST_INPUT) & adv_s & enter_pend_r;

    // Pending Enter; a consuming advance beats a coincident new edge.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            enter_pend_r <= 1'b0;
        end else if (enter_clr_s) begin
            enter_pend_r <= 1'b0;
        end else if (enter_edge_s) begin
            enter_pend_r <= 1'b1;
        end else begin
            enter_pend_r <= enter_pend_r;
        end
    end

    // State register and sticky illegal-opcode flag.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_r   <= ST_START;
            illegal_r <= 1'b0;
        end else if (adv_s) begin
            state_r   <= state_nxt_s;
            illegal_r <= illegal_r | ((state_r == ST_DECODE) & illegal_op_s);
        end else begin
            state_r   <= state_r;
            illegal_r <= illegal_r;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_START:  state_nxt_s = ST_FETCH;
            ST_FETCH:  state_nxt_s = ST_DECODE;
            ST_DECODE: begin
                if (illegal_op_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = op_to_state(op_s);
                end
            end
            ST_LOAD, ST_STORE, ST_ADD, ST_SUB, ST_JZ, ST_JPOS: state_nxt_s = ST_FETCH;
            ST_INPUT: begin
                if (enter_pend_r) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_INPUT;
                end
            end
            ST_HALT:   state_nxt_s = ST_HALT;
            default:   state_nxt_s = ST_START;
        endcase
    end

    // Moore selects held for the whole state; strobes only in the advancing cycle.
    always_comb begin
        IRload  = 1'b0;
        PCload  = 1'b0;
        Aload   = 1'b0;
        MemWr   = 1'b0;
        JMPmux  = 1'b0;
        Sub     = 1'b0;
        Meminst = 1'b0;
        Asel    = ASEL_ALU;
        Halt    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                IRload = adv_s;
                PCload = adv_s;
            end
            ST_DECODE: Meminst = 1'b1;
            ST_LOAD: begin
                Asel    = ASEL_MEM;
                Meminst = 1'b1;
                Aload   = adv_s;
            end
            ST_STORE: begin
                Meminst = 1'b1;
                MemWr   = adv_s;
            end
            ST_ADD: begin
                Meminst = 1'b1;
                Aload   = adv_s;
            end
            ST_SUB: begin
                Sub     = 1'b1;
                Meminst = 1'b1;
                Aload   = adv_s;
            end
            ST_INPUT: begin
                Asel  = ASEL_IN;
                Aload = adv_s & enter_pend_r;
            end
            ST_JZ: begin
                JMPmux = 1'b1;
                PCload = adv_s & Aeq0;
            end
            ST_JPOS: begin
                JMPmux = 1'b1;
                PCload = adv_s & Apos;
            end
            ST_HALT: Halt = 1'b1;
            default: Halt = 1'b0;
        endcase
    end

    assign Illegal = illegal_r;
    assign state   = state_r;
    assign nstate  = state_nxt_s;

endmodule

// File: tb/tb_ec_cu_stepped.sv
// Directed self-checking bench for ec_cu_stepped with DIV=4, using a 3-bit
// IR instance for normal flow and a 4-bit IR instance for the illegal trap.
module tb_ec_cu_stepped;

    logic       CLOCK_50;
    logic       Reset;
    logic [2:0] IR;
    logic [3:0] IR4;
    logic       Aeq0, Apos, Enter, Run, Step;

    logic       IRload, PCload, Aload, MemWr, JMPmux, Sub, Meminst, Halt, Illegal;
    logic [1:0] Asel;
    logic [3:0] state, nstate;

    logic       IRload4, PCload4, Aload4, MemWr4, JMPmux4, Sub4, Meminst4, Halt4, Illegal4;
    logic [1:0] Asel4;
    logic [3:0] state4, nstate4;

    logic [10:0] outs;
    assign outs = {IRload, PCload, Aload, MemWr, JMPmux, Sub, Meminst, Asel, Halt, Illegal};

    int n_pass  = 0;
    int n_total = 0;

    ec_cu_stepped #(.IR_W(3), .DIV(4), .DIV_W(3)) dut (
        .CLOCK_50 (CLOCK_50), .Reset (Reset), .IR (IR), .Aeq0 (Aeq0), .Apos (Apos),
        .Enter (Enter), .Run (Run), .Step (Step),
        .IRload (IRload), .PCload (PCload), .Aload (Aload), .MemWr (MemWr),
        .JMPmux (JMPmux), .Sub (Sub), .Meminst (Meminst), .Asel (Asel),
        .Halt (Halt), .Illegal (Illegal), .state (state), .nstate (nstate)
    );

    ec_cu_stepped #(.IR_W(4), .DIV(4), .DIV_W(3)) dut4 (
        .CLOCK_50 (CLOCK_50), .Reset (Reset), .IR (IR4), .Aeq0 (Aeq0), .Apos (Apos),
        .Enter (Enter), .Run (Run), .Step (Step),
        .IRload (IRload4), .PCload (PCload4), .Aload (Aload4), .MemWr (MemWr4),
        .JMPmux (JMPmux4), .Sub (Sub4), .Meminst (Meminst4), .Asel (Asel4),
        .Halt (Halt4), .Illegal (Illegal4), .state (state4), .nstate (nstate4)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        clks(n);
        Reset = 1'b0;
    endtask

    task automatic step_pulse();
        Step = 1'b1;
        clks(4);
        Step = 1'b0;
        clks(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        bit seen;
        logic [1:0] asel_seen;

        Reset = 1'b1; IR = 3'd0; IR4 = 4'd0; Aeq0 = 1'b0; Apos = 1'b0;
        Enter = 1'b0; Run = 1'b1; Step = 1'b0;
        clks(3);
        check("reset_state", 32'(state), 32'd0);
        check("reset_outs", 32'(outs), 32'd0);

        // 1. LOAD flow in run mode
        Reset = 1'b0;
        clks(3);
        check("t1_start_hold", 32'(state), 32'd0);
        clks(1);
        check("t1_fetch", 32'(state), 32'd1);
        check("t1_irload_idle", 32'(IRload), 32'd0);
        clks(3);
        check("t1_irload_pulse", 32'({IRload, PCload}), 32'd3);
        clks(1);
        check("t1_decode", 32'(state), 32'd2);
        check("t1_decode_meminst", 32'({Meminst, IRload}), 32'd2);
        clks(4);
        check("t1_load", 32'(state), 32'd8);
        check("t1_load_sel", 32'({Asel, Meminst, Aload}), 32'b1010);
        clks(3);
        check("t1_load_aload", 32'({Aload, Asel}), 32'b110);
        clks(1);
        check("t1_back_fetch", 32'({state, Aload}), 32'b00010);

        // 2. INPUT waits for Enter
        IR = 3'd4;
        do_reset(2);
        clks(12);
        check("t2_input", 32'(state), 32'd12);
        check("t2_input_asel", 32'(Asel), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (state != 4'd12 || Aload) bad = 1'b1;
            clks(1);
        end
        check("t2_wait_noenter", 32'(bad), 32'd0);
        Enter = 1'b1;
        seen = 1'b0;
        asel_seen = 2'b11;
        for (int i = 0; i < 24 && !seen; i++) begin
            clks(1);
            if (Aload) begin
                seen = 1'b1;
                asel_seen = Asel;
            end
        end
        check("t2_aload_seen", 32'(seen), 32'd1);
        check("t2_aload_asel", 32'(asel_seen), 32'd1);
        clks(1);
        check("t2_to_fetch", 32'(state), 32'd1);
        Enter = 1'b0;

        // 3. JZ not taken, JPOS taken
        IR = 3'd5; Aeq0 = 1'b0; Apos = 1'b0;
        do_reset(2);
        clks(12);
        check("t3_jz", 32'({state, JMPmux}), 32'b11011);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (state == 4'd13 && PCload) bad = 1'b1;
            clks(1);
        end
        check("t3_jz_no_pcload", 32'(bad), 32'd0);
        check("t3_jz_fetch", 32'(state), 32'd1);
        IR = 3'd6; Apos = 1'b1;
        clks(8);
        check("t3_jpos", 32'(state), 32'd14);
        clks(3);
        check("t3_jpos_pcload", 32'({PCload, JMPmux}), 32'd3);
        clks(1);
        check("t3_jpos_fetch", 32'(state), 32'd1);
        Apos = 1'b0;

        // 4. Single-step mode
        IR = 3'd0; Run = 1'b0;
        do_reset(2);
        clks(20);
        check("t4_ticks_ignored", 32'(state), 32'd0);
        step_pulse();
        check("t4_step1", 32'(state), 32'd1);
        step_pulse();
        check("t4_step2", 32'(state), 32'd2);
        step_pulse();
        check("t4_step3", 32'(state), 32'd8);
        Step = 1'b1;
        clks(20);
        check("t4_step_held", 32'(state), 32'd1);
        Step = 1'b0;
        clks(4);
        Run = 1'b1;

        // 5. Illegal opcode trap and legal HALT
        IR = 3'd7; IR4 = 4'b1001;
        do_reset(2);
        clks(12);
        check("t5_illegal", 32'({state4, Halt4, Illegal4}), 32'b111111);
        check("t5_legal_halt", 32'({state, Halt, Illegal}), 32'b111110);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            clks(1);
            if (state4 != 4'd15 || !Halt4 || !Illegal4) bad = 1'b1;
        end
        check("t5_halt_held", 32'(bad), 32'd0);
        do_reset(1);
        check("t5_reset_from_halt", 32'({state4, Halt4, Illegal4}), 32'd0);

        // 6. Reset mid-INPUT with a pending Enter
        IR = 3'd4;
        do_reset(2);
        clks(13);
        Enter = 1'b1;
        clks(3);
        check("t6_pending", 32'({state, Aload}), 32'b11000);
        Enter = 1'b0;
        do_reset(1);
        check("t6_reset_state", 32'(state), 32'd0);
        check("t6_reset_outs", 32'(outs), 32'd0);
        clks(12);
        check("t6_reinput", 32'(state), 32'd12);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            clks(1);
            if (state != 4'd12 || Aload) bad = 1'b1;
        end
        check("t6_stale_enter", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
